// File: rtl/pwm_regmap.sv
// Register map and shared-timebase PWM generator behind the I2C slave.
// The SCL-domain write strobe is synchronised and edge-detected; addr/data are quasi-static.
module pwm_regmap #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i2c_addr,
  input  logic [7:0]        i2c_wdata,
  input  logic              i2c_wr_en_wdata,
  output logic [7:0]        rdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_done
);

  logic       sync1, sync2, sync3;
  logic       wr_stb;
  logic       en;
  logic [7:0] prescale, period, wrap_cnt;
  logic [7:0] presc_cnt, cnt;
  logic [7:0] duty_shadow [NUM_CH];
  logic [7:0] duty_act    [NUM_CH];
  logic       restart, tick, wrap;
  logic [7:0] rd_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= i2c_wr_en_wdata;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign wr_stb  = sync2 & ~sync3;
  assign restart = wr_stb && (i2c_addr == 8'h00) && i2c_wdata[1];
  assign tick    = en && (presc_cnt == prescale);
  assign wrap    = tick && (cnt >= period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      prescale <= '0;
      period   <= '1;
      for (int unsigned n = 0; n < NUM_CH; n++) duty_shadow[n] <= '0;
    end else if (wr_stb) begin
      case (i2c_addr)
        8'h00:   en       <= i2c_wdata[0];
        8'h01:   prescale <= i2c_wdata;
        8'h02:   period   <= i2c_wdata;
        default: ;
      endcase
      for (int unsigned n = 0; n < NUM_CH; n++)
        if (i2c_addr == 8'(16 + n)) duty_shadow[n] <= i2c_wdata;
    end
  end

  // RESTART outranks the wrap so it never counts as a period or pulses period_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt   <= '0;
      cnt         <= '0;
      wrap_cnt    <= '0;
      period_done <= 1'b0;
      for (int unsigned n = 0; n < NUM_CH; n++) duty_act[n] <= '0;
    end else begin
      period_done <= 1'b0;
      if (restart || !en) begin
        presc_cnt <= '0;
        cnt       <= '0;
        for (int unsigned n = 0; n < NUM_CH; n++) duty_act[n] <= duty_shadow[n];
      end else if (tick) begin
        presc_cnt <= '0;
        if (wrap) begin
          cnt         <= '0;
          wrap_cnt    <= wrap_cnt + 8'd1;
          period_done <= 1'b1;
          for (int unsigned n = 0; n < NUM_CH; n++) duty_act[n] <= duty_shadow[n];
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        presc_cnt <= presc_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++)
        pwm_out[n] <= en && (cnt < duty_act[n]);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (i2c_addr)
      8'h00:   rd_mux = {7'b0, en};
      8'h01:   rd_mux = prescale;
      8'h02:   rd_mux = period;
      8'h20:   rd_mux = wrap_cnt;
      8'h21:   rd_mux = cnt;
      default: ;
    endcase
    for (int unsigned n = 0; n < NUM_CH; n++)
      if (i2c_addr == 8'(16 + n)) rd_mux = duty_shadow[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= rd_mux;
  end

endmodule

// File: tb/tb_pwm_regmap.sv
// Directed bench for pwm_regmap: expected PWM/period_done and read values are
// queued as stimulus is issued and popped by the sampling code.
module tb_pwm_regmap;
  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        i2c_addr, i2c_wdata;
  logic              i2c_wr_en_wdata;
  logic [7:0]        rdata;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_done;

  pwm_regmap #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_wr_en_wdata(i2c_wr_en_wdata), .rdata(rdata), .pwm_out(pwm_out),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  int unsigned total = 0, passed = 0, fails = 0;

  typedef struct {
    string             tag;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] pwm;
    logic              pd;
  } mon_t;

  mon_t       mq[$];
  logic [7:0] rq[$];
  mon_t       me;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // pwm level at sample s after a wrap sample (s=0): reflects cnt of the previous clk
  function automatic logic pbit(input int s, input int d, input int p);
    return ((s + p) % (p + 1)) < d;
  endfunction

  task automatic push(input string tag, input logic [NUM_CH-1:0] mask,
                      input logic [NUM_CH-1:0] pwm, input logic pd);
    mon_t e;
    e.tag = tag; e.mask = mask; e.pwm = pwm; e.pd = pd;
    mq.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (mq.size() > 0) begin
      me = mq.pop_front();
      check({me.tag, " pwm"}, 8'(pwm_out & me.mask), 8'(me.pwm & me.mask));
      check({me.tag, " pd"}, {7'b0, period_done}, {7'b0, me.pd});
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    i2c_addr = a; i2c_wdata = d; i2c_wr_en_wdata = 1'b1;
    repeat (3) @(posedge clk);
    repeat (5) @(negedge clk);
    i2c_wr_en_wdata = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    rq.push_back(exp);
    i2c_addr = a;
    @(negedge clk);
    check(tag, rdata, rq.pop_front());
  endtask

  task automatic wait_pd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = period_done;
    end
    check(tag, {7'b0, seen}, 8'h01);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && mq.size() > 0; i++) @(negedge clk);
    check(tag, 8'(mq.size()), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    i2c_addr = '0; i2c_wdata = '0; i2c_wr_en_wdata = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset pwm_out", 8'(pwm_out), 8'h00);
    check("reset period_done", {7'b0, period_done}, 8'h00);
    check("reset rdata", rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    rd("reset CTRL", 8'h00, 8'h00);
    rd("reset PRESCALE", 8'h01, 8'h00);
    rd("reset PERIOD", 8'h02, 8'hFF);
    rd("reset DUTY0", 8'h10, 8'h00);
    rd("reset WRAP_CNT", 8'h20, 8'h00);
    rd("reset unmapped", 8'h55, 8'h00);

    // basic PWM: PERIOD=9, duties 3/0/10/5
    wr(8'h02, 8'd9);
    wr(8'h10, 8'd3);
    wr(8'h11, 8'd0);
    wr(8'h12, 8'h0A);
    wr(8'h13, 8'd5);
    rd("DUTY2 readback", 8'h12, 8'h0A);
    wr(8'h00, 8'h01);
    wait_pd("first wrap");
    for (int s = 1; s <= 45; s++)
      push("basic", 4'hF, {pbit(s, 5, 9), pbit(s, 10, 9), pbit(s, 0, 9), pbit(s, 3, 9)},
           (s % 10) == 0);
    drain("basic drain");
    rd("WRAP_CNT after 5 periods", 8'h20, 8'd5);

    // mid-period duty write applies only from the next period
    wait_pd("glitch align");
    for (int s = 1; s <= 30; s++)
      push("glitch", 4'hF,
           {pbit(s, 5, 9), 1'b1, 1'b0, pbit(s, (s <= 10) ? 3 : 7, 9)}, (s % 10) == 0);
    repeat (2) @(negedge clk);
    wr(8'h10, 8'd7);
    drain("glitch drain");

    // PERIOD=0: wrap every tick, DUTY=1 constant high
    wr(8'h02, 8'd0);
    wr(8'h10, 8'd1);
    for (int s = 0; s < 10; s++) push("period0", 4'hF, 4'b1101, 1'b1);
    drain("period0 drain");

    // prescaler 3, then RESTART aligns cnt/presc_cnt to 0
    wr(8'h01, 8'd3);
    wr(8'h02, 8'd9);
    i2c_addr = 8'h00; i2c_wdata = 8'h03; i2c_wr_en_wdata = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i2c_addr = 8'h21;
    for (int k = 1; k <= 12; k++) rq.push_back(8'((k - 1) / 4));
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 5) i2c_wr_en_wdata = 1'b0;
      check("restart/prescale cnt", rdata, rq.pop_front());
    end
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      seen = (rdata == 8'd5);
    end
    check("cnt reaches 5", {7'b0, seen}, 8'h01);
    // PERIOD=2 lands as cnt becomes 6; next tick must wrap
    for (int j = 1; j <= 23; j++) push("period shrink", 4'b0110, 4'b0100, (j == 7) || (j == 19));
    wr(8'h02, 8'd2);
    drain("shrink drain");
    rd("CTRL after restart", 8'h00, 8'h01);

    // long strobe: exactly one write, on the 3rd clk edge
    i2c_addr = 8'h01; i2c_wdata = 8'h05; i2c_wr_en_wdata = 1'b1;
    for (int j = 1; j <= 40; j++) rq.push_back((j <= 3) ? 8'h03 : 8'h05);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 10) i2c_wdata = 8'h07;
      check("long strobe PRESCALE", rdata, rq.pop_front());
    end
    i2c_wr_en_wdata = 1'b0;
    repeat (4) @(negedge clk);
    rd("PRESCALE after long strobe", 8'h01, 8'h05);

    // EN=0: outputs low, counters held
    wr(8'h00, 8'h00);
    for (int s = 0; s < 10; s++) push("disabled", 4'hF, 4'b0000, 1'b0);
    drain("disabled drain");
    rd("CNT held at 0", 8'h21, 8'h00);

    // reset while running
    wr(8'h00, 8'h01);
    repeat (20) @(negedge clk);
    i2c_addr = 8'h02;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset pwm_out", 8'(pwm_out), 8'h00);
    check("midreset period_done", {7'b0, period_done}, 8'h00);
    check("midreset rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("post-reset PERIOD", 8'h02, 8'hFF);
    rd("post-reset DUTY2", 8'h12, 8'h00);
    rd("post-reset CTRL", 8'h00, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
